// File: rtl/mandel_pkg.sv
// Shared types and default widths for the Mandelbrot pixel dispatcher.
package mandel_pkg;
   localparam int FRAC        = 28;
   localparam int WORD_LENGTH = 32;
   localparam int COORD_W     = 11;
   localparam int DEPTH_W     = 11;

   typedef enum logic [2:0] {
      ST_IDLE, ST_LAUNCH, ST_ARM, ST_WAIT, ST_EMIT, ST_ADVANCE
   } disp_state_t;

   typedef struct packed {
      logic [DEPTH_W-1:0] depth;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic               sof;
      logic               eol;
   } pixel_beat_t;

   // A zero frame dimension is treated as one pixel/line.
   function automatic logic [COORD_W-1:0] at_least_one(input logic [COORD_W-1:0] v);
      return (v == '0) ? COORD_W'(1) : v;
   endfunction
endpackage

// File: rtl/mandel_pixel_dispatcher_if.sv
// Calculator handshake plus outgoing pixel stream of the dispatcher.
interface mandel_pixel_dispatcher_if;
   import mandel_pkg::*;
   logic                   calc_start;
   logic [COORD_W-1:0]     calc_x, calc_y;
   logic [WORD_LENGTH-1:0] calc_re_c, calc_im_c;
   logic [DEPTH_W-1:0]     calc_max_iter;
   logic                   calc_done;
   logic [DEPTH_W-1:0]     calc_depth;
   logic                   px_valid, px_ready;
   logic [DEPTH_W-1:0]     px_depth;
   logic [COORD_W-1:0]     px_x, px_y;
   logic                   px_sof, px_eol;

   modport master (
      output calc_start, calc_x, calc_y, calc_re_c, calc_im_c, calc_max_iter,
             px_valid, px_depth, px_x, px_y, px_sof, px_eol,
      input  calc_done, calc_depth, px_ready
   );
   modport slave (
      input  calc_start, calc_x, calc_y, calc_re_c, calc_im_c, calc_max_iter,
             px_valid, px_depth, px_x, px_y, px_sof, px_eol,
      output calc_done, calc_depth, px_ready
   );
endinterface

// File: rtl/mandel_pixel_dispatcher_coord_stepper.sv
// Raster x/y counters with the matching complex-plane accumulators.
module coord_stepper
   import mandel_pkg::*;
(
   input  logic                   sysclk,
   input  logic                   reset_n,
   input  logic                   load,
   input  logic                   adv,
   input  logic [WORD_LENGTH-1:0] ld_re,
   input  logic [WORD_LENGTH-1:0] ld_im,
   input  logic [WORD_LENGTH-1:0] re_origin,
   input  logic [WORD_LENGTH-1:0] step,
   input  logic [COORD_W-1:0]     width,
   input  logic [COORD_W-1:0]     height,
   output logic [COORD_W-1:0]     x,
   output logic [COORD_W-1:0]     y,
   output logic [WORD_LENGTH-1:0] re_acc,
   output logic [WORD_LENGTH-1:0] im_acc,
   output logic                   last_x,
   output logic                   last_pixel
);
   logic [COORD_W-1:0]     x_q, x_d, y_q, y_d;
   logic [WORD_LENGTH-1:0] re_q, re_d, im_q, im_d;

   assign last_x     = (x_q == width - COORD_W'(1));
   assign last_pixel = last_x && (y_q == height - COORD_W'(1));

   always_comb begin
      x_d  = x_q;
      y_d  = y_q;
      re_d = re_q;
      im_d = im_q;
      if (load) begin
         x_d  = '0;
         y_d  = '0;
         re_d = ld_re;
         im_d = ld_im;
      end else if (adv) begin
         if (last_x) begin
            // New line: image rows run downward in the imaginary axis.
            x_d  = '0;
            y_d  = y_q + COORD_W'(1);
            re_d = re_origin;
            im_d = im_q - step;
         end else begin
            x_d  = x_q + COORD_W'(1);
            re_d = re_q + step;
         end
      end
   end

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         x_q  <= '0;
         y_q  <= '0;
         re_q <= '0;
         im_q <= '0;
      end else begin
         x_q  <= x_d;
         y_q  <= y_d;
         re_q <= re_d;
         im_q <= im_d;
      end
   end

   assign x      = x_q;
   assign y      = y_q;
   assign re_acc = re_q;
   assign im_acc = im_q;
endmodule

// File: rtl/mandel_pixel_dispatcher.sv
// Walks a frame in raster order, runs one calculator per pixel, streams {depth,x,y}.
module mandel_pixel_dispatcher
   import mandel_pkg::*;
(
   input  logic                   sysclk,
   input  logic                   reset_n,
   input  logic                   frame_start,
   input  logic [COORD_W-1:0]     cfg_width,
   input  logic [COORD_W-1:0]     cfg_height,
   input  logic [DEPTH_W-1:0]     cfg_max_iter,
   input  logic [WORD_LENGTH-1:0] cfg_re_origin,
   input  logic [WORD_LENGTH-1:0] cfg_im_origin,
   input  logic [WORD_LENGTH-1:0] cfg_step,
   mandel_pixel_dispatcher_if.master io,
   output logic                   busy
);
   disp_state_t            state_q, state_d;
   logic                   busy_q, busy_d, start_q, start_d, valid_q, valid_d;
   pixel_beat_t            beat_q, beat_d;
   logic [COORD_W-1:0]     width_q, width_d, height_q, height_d;
   logic [DEPTH_W-1:0]     max_iter_q, max_iter_d;
   logic [WORD_LENGTH-1:0] re_org_q, re_org_d, im_org_q, im_org_d, step_q, step_d;
   logic                   load, adv, last_x, last_pixel;
   logic [COORD_W-1:0]     x, y;

   coord_stepper u_step (
      .sysclk, .reset_n, .load, .adv,
      .ld_re(cfg_re_origin), .ld_im(cfg_im_origin),
      .re_origin(re_org_q), .step(step_q), .width(width_q), .height(height_q),
      .x, .y, .re_acc(io.calc_re_c), .im_acc(io.calc_im_c), .last_x, .last_pixel
   );

   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      start_d    = 1'b0;
      valid_d    = valid_q;
      beat_d     = beat_q;
      width_d    = width_q;
      height_d   = height_q;
      max_iter_d = max_iter_q;
      re_org_d   = re_org_q;
      im_org_d   = im_org_q;
      step_d     = step_q;
      load       = 1'b0;
      adv        = 1'b0;
      case (state_q)
         ST_IDLE: if (frame_start) begin
            width_d    = at_least_one(cfg_width);
            height_d   = at_least_one(cfg_height);
            max_iter_d = cfg_max_iter;
            re_org_d   = cfg_re_origin;
            im_org_d   = cfg_im_origin;
            step_d     = cfg_step;
            load       = 1'b1;
            busy_d     = 1'b1;
            start_d    = 1'b1;
            state_d    = ST_LAUNCH;
         end
         ST_LAUNCH: state_d = ST_ARM;
         // done may still be high from the previous pixel; wait for it to clear.
         ST_ARM: if (!io.calc_done) state_d = ST_WAIT;
         ST_WAIT: if (io.calc_done) begin
            beat_d  = '{depth: io.calc_depth, x: x, y: y,
                        sof: (x == '0) && (y == '0), eol: last_x};
            valid_d = 1'b1;
            state_d = ST_EMIT;
         end
         ST_EMIT: if (io.px_ready) begin
            valid_d = 1'b0;
            state_d = ST_ADVANCE;
         end
         ST_ADVANCE: if (last_pixel) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end else begin
            adv     = 1'b1;
            start_d = 1'b1;
            state_d = ST_LAUNCH;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         busy_q     <= 1'b0;
         start_q    <= 1'b0;
         valid_q    <= 1'b0;
         beat_q     <= '0;
         width_q    <= '0;
         height_q   <= '0;
         max_iter_q <= '0;
         re_org_q   <= '0;
         im_org_q   <= '0;
         step_q     <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         start_q    <= start_d;
         valid_q    <= valid_d;
         beat_q     <= beat_d;
         width_q    <= width_d;
         height_q   <= height_d;
         max_iter_q <= max_iter_d;
         re_org_q   <= re_org_d;
         im_org_q   <= im_org_d;
         step_q     <= step_d;
      end
   end

   assign busy             = busy_q;
   assign io.calc_start    = start_q;
   assign io.calc_x        = x;
   assign io.calc_y        = y;
   assign io.calc_max_iter = max_iter_q;
   assign io.px_valid      = valid_q;
   assign io.px_depth      = beat_q.depth;
   assign io.px_x          = beat_q.x;
   assign io.px_y          = beat_q.y;
   assign io.px_sof        = beat_q.sof;
   assign io.px_eol        = beat_q.eol;
endmodule
